instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, max REQ cycles awaiting imem_ack before fetch error (used only with FETCH_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 PC  input  32  current program counter from the program counter stage.
REQ-005 stall  input  1  hold request from pipeline; blocks new fetch and holds the delivered instruction.
REQ-006 imem_req  output  1  instruction memory request, registered.
REQ-007 imem_addr  output  32  instruction memory address, registered.
REQ-008 imem_ack  input  1  memory accepts request and returns data in the same cycle.
REQ-009 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-010 IR  output  32  instruction register.
REQ-011 ir_valid  output  1  IR holds a freshly fetched instruction.
REQ-012 PCWr  output  1  one-cycle write enable to the program counter stage (advance to NextPC).
REQ-013 misalign  output  1  sticky flag: PC[1:0] nonzero at launch.
REQ-014 fetch_err  output  1  sticky flag: request timed out.

Function
REQ-015 FSM states IDLE, REQ, DONE, ERR; all outputs registered.
REQ-016 IDLE: stall=1 -> remain IDLE; stall=0 and PC[1:0]=00 -> imem_addr<=PC, imem_req<=1, go REQ; stall=0 and PC[1:0]!=00 -> misalign<=1, go ERR, no request issued.
REQ-017 REQ: imem_req=1 and imem_addr stable until imem_ack=1; stall ignored in REQ.
REQ-018 REQ with imem_ack=1: IR<=imem_rdata, imem_req<=0, go DONE.
REQ-019 DONE: ir_valid=1 for every DONE cycle; PCWr=1 only in the first DONE cycle; exit to IDLE on first cycle with stall=0.
REQ-020 Latency: PC sampled in IDLE cycle N; ack at earliest in cycle N+1; ir_valid and PCWr in cycle N+2; next launch no earlier than N+3.
REQ-021 imem_ack outside REQ is ignored; imem_rdata outside an ack cycle never alters IR.
REQ-022 IR retains last fetched value in IDLE, REQ and ERR.
REQ-023 ERR: sticky until reset; imem_req=0, ir_valid=0, PCWr=0.
REQ-024 PCWr never asserts twice per fetch and never asserts without a preceding acked request.
REQ-025 PC value 32'hFFFF_FFFC is fetched normally; address arithmetic is not performed in this block (no wrap handling).

Reset
REQ-026 reset=1 forces asynchronously: state IDLE, imem_req=0, imem_addr=0, IR=0, ir_valid=0, PCWr=0, misalign=0, fetch_err=0, timeout counter=0.
REQ-027 Reset mid-REQ drops request immediately; no IR update, no PCWr pulse for the aborted fetch.
REQ-028 First launch possible in the first rising edge with reset=0.

Configuration
REQ-029 Macro FETCH_TIMEOUT_EN defined: counter clears on entry to REQ, increments each REQ cycle without ack; reaching TIMEOUT_CYCLES -> imem_req<=0, fetch_err<=1, go ERR.
REQ-030 Macro FETCH_TIMEOUT_EN undefined: no counter, fetch_err tied 0, REQ waits indefinitely.

Verification
REQ-031 Reset released, PC=32'h0000_0040, stall=0, ack one cycle after req with rdata=32'h2008_0005 -> imem_addr=0x40, IR=0x20080005, ir_valid and PCWr high one cycle, IDLE next.
REQ-032 Ack delayed 5 cycles, stall pulsed in REQ -> imem_req/imem_addr stable 6 cycles, single PCWr pulse, IR updated once.
REQ-033 stall=1 during DONE for 3 cycles -> ir_valid high 3+1 cycles, PCWr high only first cycle, IR unchanged.
REQ-034 PC=32'h0000_0042 at launch -> misalign=1, imem_req never asserts, state ERR until reset.
REQ-035 With FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack withheld -> imem_req drops after 16 REQ cycles, fetch_err=1; without macro imem_req stays high.
REQ-036 reset asserted in REQ cycle 2 -> all outputs zero same cycle, no PCWr; fetch of PC=0x44 after release completes normally.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: launches one instruction-memory request per
// program-counter value, captures the returned word into IR, and pulses PCWr
// once per completed fetch. A misaligned PC parks the block in ERR until reset.
//
// Optional feature macro: FETCH_TIMEOUT_EN
//   defined   -> a request that waits TIMEOUT_CYCLES REQ cycles without
//                imem_ack is abandoned, fetch_err_o is raised and the block
//                parks in ERR.
//   undefined -> no timeout counter, fetch_err_o is tied low and a request
//                waits for imem_ack indefinitely.
module instr_fetch #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] IR_o,
    output logic        ir_valid_o,
    output logic        PCWr_o,
    output logic        misalign_o,
    output logic        fetch_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] ir_q, ir_d;
    logic        valid_q, valid_d;
    logic        pcwr_q, pcwr_d;
    logic        misalign_q, misalign_d;

`ifdef FETCH_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        ferr_q, ferr_d;
`endif

    // Next-state and next-output logic; every output is a register, so this
    // block decides what each register holds during the following cycle.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        ir_d       = ir_q;
        valid_d    = 1'b0;
        pcwr_d     = 1'b0;
        misalign_d = misalign_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d      = cnt_q;
        ferr_d     = ferr_q;
`endif

        case (state_q)
            IDLE: begin
                if (!stall_i) begin
                    if (PC_i[1:0] == 2'b00) begin
                        addr_d  = PC_i;
                        req_d   = 1'b1;
                        state_d = REQ;
`ifdef FETCH_TIMEOUT_EN
                        cnt_d   = 32'd0;
`endif
                    end else begin
                        misalign_d = 1'b1;
                        state_d    = ERR;
                    end
                end
            end

            REQ: begin
                // Stall is deliberately ignored here: once the request is on
                // the bus it must complete so address/request stay stable.
                if (imem_ack_i) begin
                    ir_d    = imem_rdata_i;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    pcwr_d  = 1'b1;
                    state_d = DONE;
                end else begin
`ifdef FETCH_TIMEOUT_EN
                    if ((cnt_q + 32'd1) >= TIMEOUT_CYCLES) begin
                        req_d   = 1'b0;
                        ferr_d  = 1'b1;
                        state_d = ERR;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
`endif
                end
            end

            DONE: begin
                // The instruction stays presented while the pipeline stalls;
                // PCWr was only armed on the REQ->DONE transition.
                if (stall_i) begin
                    valid_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end

            ERR: begin
                req_d = 1'b0;
            end

            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset to the idle state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            addr_q     <= 32'd0;
            ir_q       <= 32'd0;
            valid_q    <= 1'b0;
            pcwr_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            ir_q       <= ir_d;
            valid_q    <= valid_d;
            pcwr_q     <= pcwr_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Timeout counter and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= 32'd0;
            ferr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ferr_q <= ferr_d;
        end
    end

    assign fetch_err_o = ferr_q;
`else
    assign fetch_err_o = 1'b0;
`endif

    assign imem_req_o  = req_q;
    assign imem_addr_o = addr_q;
    assign IR_o        = ir_q;
    assign ir_valid_o  = valid_q;
    assign PCWr_o      = pcwr_q;
    assign misalign_o  = misalign_q;

endmodule
